// File: rtl/nbit_register_file.sv
// Two-read, one-write register file with a hardwired-zero register 0.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module nbit_register_file #(
    parameter int data_width   = 32,
    parameter int select_width = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    RegWrite,
    input  logic [select_width-1:0] write_address,
    input  logic [data_width-1:0]   write_data,
    input  logic [select_width-1:0] read_sel_1,
    input  logic [select_width-1:0] read_sel_2,
    output logic [data_width-1:0]   read_data_1,
    output logic [data_width-1:0]   read_data_2
);

    localparam int reg_count = 2 ** select_width;

    logic [data_width-1:0] regs [reg_count];
    logic                  write_ok;

    // Writes to register 0 are dropped here, so it stays at its reset value of zero.
    assign write_ok = RegWrite && (write_address != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < reg_count; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[write_address] <= write_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_1;
    logic fwd_2;

    assign fwd_1 = write_ok && (read_sel_1 == write_address);
    assign fwd_2 = write_ok && (read_sel_2 == write_address);
`endif

    // Holding reset forces both ports to zero regardless of what the array holds.
    always_comb begin
        read_data_1 = '0;
        if (rst_n && (read_sel_1 != '0)) begin
`ifdef REGFILE_BYPASS_EN
            read_data_1 = fwd_1 ? write_data : regs[read_sel_1];
`else
            read_data_1 = regs[read_sel_1];
`endif
        end
    end

    always_comb begin
        read_data_2 = '0;
        if (rst_n && (read_sel_2 != '0)) begin
`ifdef REGFILE_BYPASS_EN
            read_data_2 = fwd_2 ? write_data : regs[read_sel_2];
`else
            read_data_2 = regs[read_sel_2];
`endif
        end
    end

endmodule

// File: tb/tb_nbit_register_file.sv
// Directed self-checking bench for nbit_register_file at default parameters.
// Expected same-cycle read behaviour follows REGFILE_BYPASS_EN.
module tb_nbit_register_file;

    logic        clk;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [4:0]  read_sel_1;
    logic [4:0]  read_sel_2;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;

    int n_cmp  = 0;
    int n_fail = 0;

    nbit_register_file #(
        .data_width  (32),
        .select_width(5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RegWrite     (RegWrite),
        .write_address(write_address),
        .write_data   (write_data),
        .read_sel_1   (read_sel_1),
        .read_sel_2   (read_sel_2),
        .read_data_1  (read_data_1),
        .read_data_2  (read_data_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, let it land on the next rising edge, sample 1ns later.
    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        RegWrite      = 1'b1;
        write_address = addr;
        write_data    = data;
        @(posedge clk);
        #1;
        RegWrite      = 1'b0;
    endtask

    task automatic set_reads(input logic [4:0] s1, input logic [4:0] s2);
        read_sel_1 = s1;
        read_sel_2 = s2;
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        RegWrite      = 1'b0;
        write_address = '0;
        write_data    = '0;
        read_sel_1    = '0;
        read_sel_2    = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            set_reads(5'(i), 5'(31 - i));
            n_cmp++;
            if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
                n_fail++;
                $display("FAIL in_reset sel=%0d: rd1=%h rd2=%h, required 0/0", i, read_data_1, read_data_2);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_reads(5'd1, 5'd2);
        n_cmp++;
        if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
            n_fail++;
            $display("FAIL after_reset: rd1=%h rd2=%h, required 0/0", read_data_1, read_data_2);
        end
    endtask

    task automatic test_write_read();
        do_write(5'd2, 32'hFFFF_FFFF);
        set_reads(5'd2, 5'd0);
        n_cmp++;
        if (read_data_1 !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL write_r2: rd1=%h, required ffffffff", read_data_1);
        end
        do_write(5'd5, 32'hEEEE_EEEE);
        set_reads(5'd2, 5'd5);
        n_cmp++;
        if (read_data_2 !== 32'hEEEE_EEEE) begin
            n_fail++;
            $display("FAIL write_r5: rd2=%h, required eeeeeeee", read_data_2);
        end
        n_cmp++;
        if (read_data_1 !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL r2_kept: rd1=%h, required ffffffff", read_data_1);
        end
    endtask

    task automatic test_zero_reg();
        do_write(5'd0, 32'h1234_5678);
        set_reads(5'd0, 5'd0);
        n_cmp++;
        if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_reg: rd1=%h rd2=%h, required 0/0", read_data_1, read_data_2);
        end
        // A write to 0 while reading 0 must not forward either.
        @(negedge clk);
        RegWrite      = 1'b1;
        write_address = 5'd0;
        write_data    = 32'hCAFE_F00D;
        set_reads(5'd0, 5'd0);
        n_cmp++;
        if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_no_fwd: rd1=%h rd2=%h, required 0/0", read_data_1, read_data_2);
        end
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
    endtask

    task automatic test_dual_same_reg();
        set_reads(5'd5, 5'd5);
        n_cmp++;
        if (read_data_1 !== 32'hEEEE_EEEE || read_data_2 !== 32'hEEEE_EEEE) begin
            n_fail++;
            $display("FAIL dual_same: rd1=%h rd2=%h, required eeeeeeee/eeeeeeee", read_data_1, read_data_2);
        end
    endtask

    task automatic test_write_disabled();
        @(negedge clk);
        RegWrite      = 1'b0;
        write_address = 5'd9;
        write_data    = 32'h9999_9999;
        @(posedge clk);
        #1;
        set_reads(5'd9, 5'd2);
        n_cmp++;
        if (read_data_1 !== 32'h0) begin
            n_fail++;
            $display("FAIL no_we_r9: rd1=%h, required 0", read_data_1);
        end
        n_cmp++;
        if (read_data_2 !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL no_we_r2: rd2=%h, required ffffffff", read_data_2);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_before;
`ifdef REGFILE_BYPASS_EN
        exp_before = 32'hA5A5_A5A5;
`else
        exp_before = 32'h0;
`endif
        @(negedge clk);
        RegWrite      = 1'b1;
        write_address = 5'd7;
        write_data    = 32'hA5A5_A5A5;
        set_reads(5'd7, 5'd2);
        n_cmp++;
        if (read_data_1 !== exp_before) begin
            n_fail++;
            $display("FAIL same_cycle_before: rd1=%h, required %h", read_data_1, exp_before);
        end
        n_cmp++;
        if (read_data_2 !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL same_cycle_other: rd2=%h, required ffffffff", read_data_2);
        end
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        #1;
        n_cmp++;
        if (read_data_1 !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL same_cycle_after: rd1=%h, required a5a5a5a5", read_data_1);
        end
    endtask

    task automatic test_walk();
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'h0101_0101 * i);
        end
        for (int i = 1; i < 32; i++) begin
            set_reads(5'(i), 5'(32 - i));
            n_cmp++;
            if (read_data_1 !== 32'h0101_0101 * i || read_data_2 !== 32'h0101_0101 * (32 - i)) begin
                n_fail++;
                $display("FAIL walk sel=%0d/%0d: rd1=%h rd2=%h, required %h/%h", i, 32 - i,
                         read_data_1, read_data_2, 32'h0101_0101 * i, 32'h0101_0101 * (32 - i));
            end
        end
    endtask

    task automatic test_reset_priority();
        do_write(5'd2, 32'hFFFF_FFFF);
        do_write(5'd5, 32'hEEEE_EEEE);
        @(negedge clk);
        rst_n         = 1'b0;
        RegWrite      = 1'b1;
        write_address = 5'd3;
        write_data    = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n    = 1'b1;
        RegWrite = 1'b0;
        set_reads(5'd2, 5'd3);
        n_cmp++;
        if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_prio r2/r3: rd1=%h rd2=%h, required 0/0", read_data_1, read_data_2);
        end
        set_reads(5'd5, 5'd31);
        n_cmp++;
        if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_prio r5/r31: rd1=%h rd2=%h, required 0/0", read_data_1, read_data_2);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_dual_same_reg();
        test_write_disabled();
        test_same_cycle();
        test_walk();
        test_reset_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
